// File: rtl/dm_hart_ctrl.sv
// dm_hart_ctrl: debug-module hart run control (halt strobe, resume handshake, dmstatus bits).
// Optional macro DM_HALT_TIMEOUT_EN adds a halt timeout counter and the halt_timeout_o port.
module dm_hart_ctrl #(
  parameter int unsigned RETRY_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dmactive_i,
  input  logic dmctl_we_i,
  input  logic haltreq_i,
  input  logic resumereq_i,
  input  logic ackhavereset_i,
  input  logic ndmreset_i,
  input  logic core_halted_i,
  output logic debug_strobe_o,
  output logic resume_req_o,
  output logic ndmreset_o,
  output logic allhalted_o,
  output logic allrunning_o,
  output logic resumeack_o,
  output logic havereset_o,
`ifdef DM_HALT_TIMEOUT_EN
  output logic halt_timeout_o,
`endif
  output logic busy_o
);

  typedef enum logic [1:0] {
    ST_RUNNING     = 2'd0,
    ST_HALT_WAIT   = 2'd1,
    ST_HALTED      = 2'd2,
    ST_RESUME_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  if ((TIMEOUT_CYC > (32'd1 << CNT_W)) || (RETRY_CYC > (32'd1 << CNT_W))) begin : g_cfg_err
    $error("dm_hart_ctrl: CNT_W too narrow for RETRY_CYC/TIMEOUT_CYC");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic             strobe_q, strobe_d;
  logic             resume_req_q, resume_req_d;
  logic             ndmreset_q, ndmreset_d;
  logic             allhalted_q, allhalted_d;
  logic             allrunning_q, allrunning_d;
  logic             resumeack_q, resumeack_d;
  logic             havereset_q, havereset_d;
  logic             busy_q, busy_d;
  logic             halt_ok_s;
  logic             resume_wr_s;

`ifdef DM_HALT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  logic             blocked_q, blocked_d;
`endif

  // Resume only counts when it is not overridden by a simultaneous halt request.
  assign resume_wr_s = dmctl_we_i & resumereq_i & ~haltreq_i;

  // Next-state and next-output computation for the run-control FSM.
  always_comb begin
    state_d      = state_q;
    strobe_d     = 1'b0;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    retry_cnt_d  = retry_cnt_q;
    ndmreset_d   = ndmreset_i;
`ifdef DM_HALT_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    blocked_d = blocked_q & haltreq_i;
    halt_ok_s = haltreq_i & ~blocked_q;
    if (dmctl_we_i && !haltreq_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
`else
    halt_ok_s = haltreq_i;
`endif
    if (ndmreset_q && !ndmreset_i) begin
      havereset_d = 1'b1;
    end else if (dmctl_we_i && ackhavereset_i) begin
      havereset_d = 1'b0;
    end else begin
      havereset_d = havereset_q;
    end

    if (!dmactive_i) begin
      state_d      = ST_RUNNING;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      retry_cnt_d  = CNT_ZERO;
      ndmreset_d   = 1'b0;
      havereset_d  = havereset_q;
`ifdef DM_HALT_TIMEOUT_EN
      tmo_cnt_d = CNT_ZERO;
      timeout_d = 1'b0;
      blocked_d = 1'b0;
`endif
    end else if (ndmreset_i) begin
      state_d      = ST_RUNNING;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      retry_cnt_d  = CNT_ZERO;
`ifdef DM_HALT_TIMEOUT_EN
      tmo_cnt_d = CNT_ZERO;
`endif
    end else begin
      case (state_q)
        ST_RUNNING: begin
          if (halt_ok_s) begin
            state_d     = ST_HALT_WAIT;
            strobe_d    = 1'b1;
            retry_cnt_d = CNT_ZERO;
`ifdef DM_HALT_TIMEOUT_EN
            tmo_cnt_d = CNT_ZERO;
`endif
          end else if (core_halted_i) begin
            state_d = ST_HALTED;
          end else if (resume_wr_s) begin
            resumeack_d = 1'b1;
          end else begin
            state_d = ST_RUNNING;
          end
        end
        ST_HALT_WAIT: begin
`ifdef DM_HALT_TIMEOUT_EN
          tmo_cnt_d = sat_inc(tmo_cnt_q);
`endif
          if (core_halted_i) begin
            state_d = ST_HALTED;
`ifdef DM_HALT_TIMEOUT_EN
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_d   = ST_RUNNING;
            timeout_d = 1'b1;
            blocked_d = 1'b1;
`endif
          end else if (retry_cnt_q == RETRY_LAST) begin
            // Re-pulse in case the first strobe was lost while the core stalled.
            strobe_d    = 1'b1;
            retry_cnt_d = CNT_ZERO;
          end else begin
            retry_cnt_d = sat_inc(retry_cnt_q);
          end
        end
        ST_HALTED: begin
          if (resume_wr_s) begin
            state_d      = ST_RESUME_WAIT;
            resumeack_d  = 1'b0;
            resume_req_d = 1'b1;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_RESUME_WAIT: begin
          if (!core_halted_i) begin
            state_d      = ST_RUNNING;
            resume_req_d = 1'b0;
            resumeack_d  = 1'b1;
          end else begin
            resume_req_d = 1'b1;
          end
        end
        default: begin
          state_d      = ST_RUNNING;
          resume_req_d = 1'b0;
          retry_cnt_d  = CNT_ZERO;
        end
      endcase
    end

    allhalted_d  = dmactive_i & core_halted_i;
    allrunning_d = ~allhalted_d & (state_d != ST_HALT_WAIT);
    busy_d       = (state_d == ST_HALT_WAIT) | (state_d == ST_RESUME_WAIT);
  end

  // State and registered-output update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUNNING;
      retry_cnt_q  <= CNT_ZERO;
      strobe_q     <= 1'b0;
      resume_req_q <= 1'b0;
      ndmreset_q   <= 1'b0;
      allhalted_q  <= 1'b0;
      allrunning_q <= 1'b1;
      resumeack_q  <= 1'b0;
      havereset_q  <= 1'b1;
      busy_q       <= 1'b0;
`ifdef DM_HALT_TIMEOUT_EN
      tmo_cnt_q <= CNT_ZERO;
      timeout_q <= 1'b0;
      blocked_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      retry_cnt_q  <= retry_cnt_d;
      strobe_q     <= strobe_d;
      resume_req_q <= resume_req_d;
      ndmreset_q   <= ndmreset_d;
      allhalted_q  <= allhalted_d;
      allrunning_q <= allrunning_d;
      resumeack_q  <= resumeack_d;
      havereset_q  <= havereset_d;
      busy_q       <= busy_d;
`ifdef DM_HALT_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      blocked_q <= blocked_d;
`endif
    end
  end

  assign debug_strobe_o = strobe_q;
  assign resume_req_o   = resume_req_q;
  assign ndmreset_o     = ndmreset_q;
  assign allhalted_o    = allhalted_q;
  assign allrunning_o   = allrunning_q;
  assign resumeack_o    = resumeack_q;
  assign havereset_o    = havereset_q;
  assign busy_o         = busy_q;
`ifdef DM_HALT_TIMEOUT_EN
  assign halt_timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed self-checking bench for dm_hart_ctrl; set DM_HALT_TIMEOUT_EN to add the timeout scenario.
`timescale 1ns/1ps
module tb_dm_hart_ctrl;

`ifdef DM_HALT_TIMEOUT_EN
  localparam int unsigned TMO = 64;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic clk_i = 1'b0;
  logic rst_ni, dmactive_i, dmctl_we_i, haltreq_i, resumereq_i, ackhavereset_i, ndmreset_i, core_halted_i;
  logic debug_strobe_o, resume_req_o, ndmreset_o, allhalted_o, allrunning_o, resumeack_o, havereset_o, busy_o;
`ifdef DM_HALT_TIMEOUT_EN
  logic halt_timeout_o;
`endif
  logic [7:0] outs;
  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;

  always #5 clk_i = ~clk_i;

  dm_hart_ctrl #(.RETRY_CYC(16), .TIMEOUT_CYC(TMO), .CNT_W(11)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i), .dmctl_we_i(dmctl_we_i),
    .haltreq_i(haltreq_i), .resumereq_i(resumereq_i), .ackhavereset_i(ackhavereset_i),
    .ndmreset_i(ndmreset_i), .core_halted_i(core_halted_i),
    .debug_strobe_o(debug_strobe_o), .resume_req_o(resume_req_o), .ndmreset_o(ndmreset_o),
    .allhalted_o(allhalted_o), .allrunning_o(allrunning_o), .resumeack_o(resumeack_o),
    .havereset_o(havereset_o),
`ifdef DM_HALT_TIMEOUT_EN
    .halt_timeout_o(halt_timeout_o),
`endif
    .busy_o(busy_o)
  );

  // {strobe, resume_req, ndmreset, allhalted, allrunning, resumeack, havereset, busy}
  assign outs = {debug_strobe_o, resume_req_o, ndmreset_o, allhalted_o,
                 allrunning_o, resumeack_o, havereset_o, busy_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (debug_strobe_o === 1'b1) strobe_cnt++;
  endtask

  initial begin
    rst_ni = 1'b0; dmactive_i = 1'b1; dmctl_we_i = 1'b0; haltreq_i = 1'b0; resumereq_i = 1'b0;
    ackhavereset_i = 1'b0; ndmreset_i = 1'b0; core_halted_i = 1'b0;
    #23;
    check("reset_vals", outs, 8'b0000_1010);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick();
    check("post_reset", outs, 8'b0000_1010);
    dmctl_we_i = 1'b1; ackhavereset_i = 1'b1;
    tick();
    check("ack_initial", outs, 8'b0000_1000);
    dmctl_we_i = 1'b0; ackhavereset_i = 1'b0;
    tick();

    // Halt: strobe on HALT_WAIT entry, HALTED one cycle after core_halted rises.
    haltreq_i = 1'b1; strobe_cnt = 0;
    tick(); check("halt_entry", outs, 8'b1000_0001);
    tick(); check("halt_wait1", outs, 8'b0000_0001);
    tick(); tick(); check("halt_wait3", outs, 8'b0000_0001);
    core_halted_i = 1'b1;
    tick(); check("halted", outs, 8'b0001_0000);
    check("halt_strobes", strobe_cnt, 32'd1);
    tick(); check("halted_haltreq_noop", outs, 8'b0001_0000);
    haltreq_i = 1'b0;

    // Resume handshake.
    dmctl_we_i = 1'b1; resumereq_i = 1'b1;
    tick(); check("resume_wait", outs, 8'b0101_0001);
    dmctl_we_i = 1'b0; resumereq_i = 1'b0;
    tick(); tick(); check("resume_hold", outs, 8'b0101_0001);
    core_halted_i = 1'b0;
    tick(); check("resumed", outs, 8'b0000_1100);

    // Retry strobes every 16 cycles while the core never halts.
    haltreq_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("retry_strobe_%0d", i), debug_strobe_o, ((i % 16) == 0) ? 32'd1 : 32'd0);
      check($sformatf("retry_busy_%0d", i), busy_o, 32'd1);
    end
    core_halted_i = 1'b1;
    tick(); check("retry_halted", outs, 8'b0001_0100);
    haltreq_i = 1'b0;

    // Simultaneous halt+resume write while halted: halt wins.
    dmctl_we_i = 1'b1; haltreq_i = 1'b1; resumereq_i = 1'b1; strobe_cnt = 0;
    tick(); check("conflict", outs, 8'b0001_0100);
    dmctl_we_i = 1'b0; haltreq_i = 1'b0; resumereq_i = 1'b0;
    tick(); check("conflict_after", outs, 8'b0001_0100);
    check("conflict_strobes", strobe_cnt, 32'd0);

    // haltreq during RESUME_WAIT is deferred until RUNNING.
    dmctl_we_i = 1'b1; resumereq_i = 1'b1;
    tick(); check("resume2_wait", outs, 8'b0101_0001);
    dmctl_we_i = 1'b0; resumereq_i = 1'b0; haltreq_i = 1'b1;
    tick(); check("holdoff_wait", outs, 8'b0101_0001);
    core_halted_i = 1'b0;
    tick(); check("holdoff_running", outs, 8'b0000_1100);
    tick(); check("holdoff_strobe", outs, 8'b1000_0101);
    tick(); tick(); check("hw_again", outs, 8'b0000_0101);

    // ndmreset mid-HALT_WAIT.
    ndmreset_i = 1'b1; strobe_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); check($sformatf("ndmreset_%0d", i), outs, 8'b0010_1000);
    end
    ndmreset_i = 1'b0; haltreq_i = 1'b0;
    tick(); check("ndm_release", outs, 8'b0000_1010);
    check("ndm_strobes", strobe_cnt, 32'd0);
    dmctl_we_i = 1'b1; ackhavereset_i = 1'b1;
    tick(); check("ack_havereset", outs, 8'b0000_1000);
    dmctl_we_i = 1'b0; ackhavereset_i = 1'b0;

    // havereset set beats same-cycle ack.
    ndmreset_i = 1'b1;
    tick(); check("ndm2_on", outs, 8'b0010_1000);
    ndmreset_i = 1'b0; dmctl_we_i = 1'b1; ackhavereset_i = 1'b1;
    tick(); check("set_beats_clear", outs, 8'b0000_1010);
    tick(); check("ack_clear2", outs, 8'b0000_1000);
    ackhavereset_i = 1'b0;

    // Resume write while running only acks.
    resumereq_i = 1'b1;
    tick(); check("run_resume_ack", outs, 8'b0000_1100);
    dmctl_we_i = 1'b0; resumereq_i = 1'b0;

    // Core halts on its own (ebreak): straight to HALTED, no strobe.
    core_halted_i = 1'b1; strobe_cnt = 0;
    tick(); check("ebreak_halted", outs, 8'b0001_0100);
    check("ebreak_strobes", strobe_cnt, 32'd0);

    // dmactive low mid-HALT_WAIT: soft reset, havereset held.
    dmctl_we_i = 1'b1; resumereq_i = 1'b1;
    tick(); dmctl_we_i = 1'b0; resumereq_i = 1'b0; core_halted_i = 1'b0;
    tick(); haltreq_i = 1'b1;
    tick(); check("pre_dmactive", outs, 8'b1000_0101);
    dmactive_i = 1'b0;
    tick(); check("dmactive_low", outs, 8'b0000_1000);
    dmactive_i = 1'b1; haltreq_i = 1'b0;
    tick(); check("dmactive_back", outs, 8'b0000_1000);

`ifdef DM_HALT_TIMEOUT_EN
    // Timeout after 64 cycles; haltreq must drop before a new attempt.
    haltreq_i = 1'b1;
    for (int i = 0; i < 75; i++) begin
      tick();
      check($sformatf("tmo_strobe_%0d", i), debug_strobe_o, (i < 64 && (i % 16) == 0) ? 32'd1 : 32'd0);
      check($sformatf("tmo_busy_%0d", i), busy_o, (i < 64) ? 32'd1 : 32'd0);
      check($sformatf("tmo_flag_%0d", i), halt_timeout_o, (i >= 64) ? 32'd1 : 32'd0);
    end
    haltreq_i = 1'b0;
    tick(); check("tmo_sticky", {halt_timeout_o, busy_o}, 32'd2);
    haltreq_i = 1'b1;
    tick(); check("tmo_rearm", {halt_timeout_o, debug_strobe_o, busy_o}, 32'd7);
    core_halted_i = 1'b1;
    tick(); haltreq_i = 1'b0; dmctl_we_i = 1'b1;
    tick(); check("tmo_clear", {halt_timeout_o, allhalted_o}, 32'd1);
    dmctl_we_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
